wl_cg_ctrl: RTL
===============

# wl_cg_ctrl

Clock-gate enable controller that drives the per-domain `en` inputs of the `wl_clkgate` ICG bank. For each of `CLK_NUM` gated domains it detects sustained idleness and drops the enable. It re-enables the clock on a busy or wake request and returns an acknowledge once the gated clock is guaranteed to be running. It sits in the always-on clock domain of the GEMM top, between the compute/requester logic and the clock-gate cells.

## Interface
Parameters:
- `CLK_NUM`, 1, number of independently gated domains.
- `IDLE_CNT_W`, 8, width of the idle counter and the threshold.
- `WAKE_LAT`, 2, cycles the enable is held before ack; covers the synchronous-CE latency of the gate cell. Must be ≥1.

Ports:
- `clk_i`  in  1  always-on (ungated) clock. All sequential logic is clocked on it.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `dft_se`  in  1  scan enable; forces every `en_o` bit high.
- `force_on_i`  in  1  software override; forces every `en_o` bit high.
- `idle_thr_i`  in  IDLE_CNT_W  idle cycles required before gating. 0 disables gating.
- `busy_i`  in  CLK_NUM  domain has work in flight.
- `wake_req_i`  in  CLK_NUM  level request for a running clock; held until acked.
- `wake_ack_o`  out  CLK_NUM  domain clock guaranteed running.
- `en_o`  out  CLK_NUM  enable to the ICG bank.
- `gated_o`  out  CLK_NUM  domain currently gated (status).

## Operation
- Each domain has an independent FSM with states ON, OFF and WAKE, plus one IDLE_CNT_W counter.
- Reset state: ON, counter 0. Reset values: `en_o` all 1, `wake_ack_o` all 1, `gated_o` all 0. Reset is asynchronous, so mid-operation reset re-enables the clocks immediately.
- Idle cycle: `busy_i[i]==0 && wake_req_i[i]==0`.
- ON:
  - A non-idle cycle clears the counter.
  - An idle cycle increments the counter, saturating at all-ones.
  - On an idle cycle with `idle_thr_i!=0` and `counter+1 >= idle_thr_i` (unsigned, IDLE_CNT_W+1 bits), go to OFF and clear the counter.
  - `force_on_i==1` holds the counter at 0.
- OFF: on `busy_i[i] | wake_req_i[i] | force_on_i`, go to WAKE and clear the counter.
- WAKE:
  - The counter increments every cycle.
  - When `counter == WAKE_LAT-1`, go to ON and clear the counter.
  - Requests are ignored while in WAKE; there is no return to OFF from WAKE.
- Output decode:
  - `en_o[i] = (state!=OFF) | dft_se | force_on_i`. `dft_se` and `force_on_i` are ORed combinationally after the flop; everything else comes straight from state flops.
  - `wake_ack_o[i] = (state==ON)`.
  - `gated_o[i] = (state==OFF)`.
- `idle_thr_i` is sampled every cycle. If the threshold is lowered below the current count, the domain gates on the next idle cycle.
- `busy_i` and `wake_req_i` both high in the same cycle: no different from either alone.

## Timing
- Gating latency: domain idle from cycle N with threshold T≥1 gives `en_o` low at the first edge after cycle N+T-1, i.e. visible in cycle N+T.
- Wake latency: request seen in OFF at cycle N gives `en_o` high in cycle N+1 (WAKE). `wake_ack_o` goes high in cycle N+1+WAKE_LAT.
- Handshake:
  - The requester raises `wake_req_i` and holds it until it samples `wake_ack_o==1`.
  - While the request stays high in ON, gating is inhibited.
  - Ack is a level, not a pulse.
- A request arriving in ON is acked in the same cycle; there is zero added latency.
- `en_o` never glitches low while `dft_se` or `force_on_i` is high.

## Structure
- Shared package `wl_cg_pkg`:
  - FSM state typedef (2-bit: ON=0, WAKE=1, OFF=2).
  - `WL_CG_WAKE_LAT_DEF` constant.
- Sub-module `wl_cg_ctrl_ch`:
  - Contains one domain's FSM plus counter.
  - The top instantiates it `CLK_NUM` times in a generate loop and does the shared `dft_se`/`force_on_i` OR.

## Test plan
- Reset release with `busy_i=0` and `idle_thr_i=4` gives `en_o=1` for cycles 0–3 after release, `en_o=0` and `gated_o=1` from cycle 4.
- From OFF, pulse `busy_i[0]` for 1 cycle (WAKE_LAT=2): `en_o[0]=1` next cycle, `wake_ack_o[0]=1` 3 cycles after the pulse, then the domain re-gates after 4 idle cycles.
- Hold `wake_req_i[1]` in ON for 100 cycles with `idle_thr_i=1`: `en_o[1]` stays 1 throughout; ack is continuous; gating occurs 1 cycle after release.
- With `idle_thr_i=0` and 300 idle cycles: no gating, and the counter saturates at 255 without wrap. Then set `idle_thr_i=10`: gate on the next idle cycle.
- Assert `dft_se` while OFF: `en_o` is 1 combinationally and `gated_o` stays 1. Deassert: `en_o` returns to 0.
- Assert `rst_ni` low mid-WAKE: `en_o=1` and `wake_ack_o=1` immediately (asynchronous), with no clock edge required.

Source files
------------

// File: rtl/wl_cg_pkg.sv
// -----------------------------------------------------------------------------
// wl_cg_pkg
// Shared types and constants for the clock-gate enable controller
// (wl_cg_ctrl and its per-domain channel wl_cg_ctrl_ch).
//
// Contents:
//   cg_state_e            per-domain FSM state (2-bit: ON=0, WAKE=1, OFF=2)
//   WL_CG_WAKE_LAT_DEF    default enable-to-ack latency in cycles
//   WL_CG_IDLE_CNT_W_DEF  default idle counter / threshold width
//   cg_is_idle()          idle-cycle qualifier for one domain
// -----------------------------------------------------------------------------
package wl_cg_pkg;

  typedef enum logic [1:0] {
    CG_ON   = 2'd0,
    CG_WAKE = 2'd1,
    CG_OFF  = 2'd2
  } cg_state_e;

  localparam int WL_CG_WAKE_LAT_DEF   = 2;
  localparam int WL_CG_IDLE_CNT_W_DEF = 8;

  // A domain is idle only when it has no work and nobody wants its clock.
  function automatic logic cg_is_idle(input logic busy, input logic wake_req);
    return !busy && !wake_req;
  endfunction

endpackage : wl_cg_pkg

// File: rtl/wl_cg_ctrl_ch.sv
// -----------------------------------------------------------------------------
// wl_cg_ctrl_ch
// One gated domain: ON/WAKE/OFF state machine plus a shared idle/wake counter.
// In ON the counter measures consecutive idle cycles; in WAKE it measures the
// time the enable has been held so the ack is only given once the ICG's
// synchronous-CE latency has elapsed.
//
// Ports:
//   clk_i       in   always-on clock
//   rst_ni      in   asynchronous active-low reset (state ON, counter 0)
//   force_on_i  in   software override: keeps the domain awake
//   idle_thr_i  in   idle cycles before gating, 0 = never gate
//   busy_i      in   domain has work in flight
//   wake_req_i  in   level request for a running clock
//   wake_ack_o  out  state is ON (clock guaranteed running)
//   gated_o     out  state is OFF (enable dropped)
// -----------------------------------------------------------------------------
module wl_cg_ctrl_ch
  import wl_cg_pkg::*;
#(
  parameter int IDLE_CNT_W = WL_CG_IDLE_CNT_W_DEF,
  parameter int WAKE_LAT   = WL_CG_WAKE_LAT_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  force_on_i,
  input  logic [IDLE_CNT_W-1:0] idle_thr_i,
  input  logic                  busy_i,
  input  logic                  wake_req_i,
  output logic                  wake_ack_o,
  output logic                  gated_o
);

  // The WAKE phase reuses the idle counter, so WAKE_LAT-1 must fit in it.
  localparam logic [IDLE_CNT_W-1:0] WAKE_LAST = IDLE_CNT_W'(WAKE_LAT - 1);
  localparam logic [IDLE_CNT_W-1:0] CNT_ONE   = IDLE_CNT_W'(1);
  localparam logic [IDLE_CNT_W:0]   WIDE_ONE  = (IDLE_CNT_W + 1)'(1);

  cg_state_e             state_reg, state_next;
  logic [IDLE_CNT_W-1:0] cnt_reg, cnt_next;

  logic                  idle;
  logic [IDLE_CNT_W:0]   cnt_plus_one;
  logic                  thr_hit;
  logic [IDLE_CNT_W-1:0] cnt_sat_inc;

  assign idle = cg_is_idle(busy_i, wake_req_i);

  // Compare one bit wider than the counter so a saturated count still
  // reaches any threshold, including all-ones.
  assign cnt_plus_one = {1'b0, cnt_reg} + WIDE_ONE;
  assign thr_hit      = (idle_thr_i != '0) && (cnt_plus_one >= {1'b0, idle_thr_i});

  // Idle counting must never wrap back to a small value.
  assign cnt_sat_inc  = (&cnt_reg) ? cnt_reg : (cnt_reg + CNT_ONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= CG_ON;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      CG_ON: begin
        if (force_on_i || !idle) begin
          // Override or activity: restart the idle window, never gate.
          cnt_next = '0;
        end else if (thr_hit) begin
          state_next = CG_OFF;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_sat_inc;
        end
      end
      CG_OFF: begin
        if (!idle || force_on_i) begin
          state_next = CG_WAKE;
          cnt_next   = '0;
        end
      end
      CG_WAKE: begin
        // Requests are irrelevant here: the wake always runs to completion.
        if (cnt_reg == WAKE_LAST) begin
          state_next = CG_ON;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = CG_ON;
        cnt_next   = '0;
      end
    endcase
  end

  // Pure state decode so the status/ack outputs come straight off the flops.
  assign wake_ack_o = (state_reg == CG_ON);
  assign gated_o    = (state_reg == CG_OFF);

endmodule : wl_cg_ctrl_ch

// File: rtl/wl_cg_ctrl.sv
// -----------------------------------------------------------------------------
// wl_cg_ctrl
// Clock-gate enable controller for the wl_clkgate ICG bank. Each of CLK_NUM
// domains is gated after idle_thr_i consecutive idle cycles and re-enabled on
// busy/wake request; wake_ack_o rises once the gated clock is known running.
// Runs entirely on the always-on clock.
//
// Ports:
//   clk_i       in   always-on (ungated) clock
//   rst_ni      in   asynchronous active-low reset
//   dft_se      in   scan enable, forces every en_o bit high
//   force_on_i  in   software override, forces every en_o bit high
//   idle_thr_i  in   idle cycles required before gating, 0 disables gating
//   busy_i      in   per-domain work in flight
//   wake_req_i  in   per-domain level wake request, held until acked
//   wake_ack_o  out  per-domain clock guaranteed running
//   en_o        out  per-domain enable to the ICG bank
//   gated_o     out  per-domain currently gated (status)
// -----------------------------------------------------------------------------
module wl_cg_ctrl
  import wl_cg_pkg::*;
#(
  parameter int CLK_NUM    = 1,
  parameter int IDLE_CNT_W = WL_CG_IDLE_CNT_W_DEF,
  parameter int WAKE_LAT   = WL_CG_WAKE_LAT_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dft_se,
  input  logic                  force_on_i,
  input  logic [IDLE_CNT_W-1:0] idle_thr_i,
  input  logic [CLK_NUM-1:0]    busy_i,
  input  logic [CLK_NUM-1:0]    wake_req_i,
  output logic [CLK_NUM-1:0]    wake_ack_o,
  output logic [CLK_NUM-1:0]    en_o,
  output logic [CLK_NUM-1:0]    gated_o
);

  logic [CLK_NUM-1:0] gated_vec;
  logic               en_force;

  for (genvar gi = 0; gi < CLK_NUM; gi++) begin : g_ch
    wl_cg_ctrl_ch #(
      .IDLE_CNT_W (IDLE_CNT_W),
      .WAKE_LAT   (WAKE_LAT)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .force_on_i (force_on_i),
      .idle_thr_i (idle_thr_i),
      .busy_i     (busy_i[gi]),
      .wake_req_i (wake_req_i[gi]),
      .wake_ack_o (wake_ack_o[gi]),
      .gated_o    (gated_vec[gi])
    );
  end

  // The overrides are ORed after the state flops so scan/software can hold
  // the clocks on without waiting for an edge, and the enable cannot dip
  // low while either override is asserted.
  assign en_force = dft_se | force_on_i;
  assign en_o     = ~gated_vec | {CLK_NUM{en_force}};
  assign gated_o  = gated_vec;

endmodule : wl_cg_ctrl
